// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared encodings for the execute stage and its mul/div unit
package ex_pkg;

    localparam logic [1:0] ALUOP_LOAD_STORE = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH     = 2'b01;
    localparam logic [1:0] ALUOP_R_TYPE     = 2'b10;
    localparam logic [1:0] ALUOP_I_TYPE     = 2'b11;

    localparam logic [1:0] FW_REG   = 2'b00;
    localparam logic [1:0] FW_ZERO  = 2'b01;
    localparam logic [1:0] FW_MEMWB = 2'b10;
    localparam logic [1:0] FW_EXMEM = 2'b11;

    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [5:0] FUNC_SLL   = 6'b000000;
    localparam logic [5:0] FUNC_SRL   = 6'b000010;
    localparam logic [5:0] FUNC_SRA   = 6'b000011;
    localparam logic [5:0] FUNC_JALR  = 6'b001001;
    localparam logic [5:0] FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;
    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;
    localparam logic [5:0] FUNC_ADD   = 6'b100000;
    localparam logic [5:0] FUNC_ADDU  = 6'b100001;
    localparam logic [5:0] FUNC_SUB   = 6'b100010;
    localparam logic [5:0] FUNC_SUBU  = 6'b100011;
    localparam logic [5:0] FUNC_AND   = 6'b100100;
    localparam logic [5:0] FUNC_OR    = 6'b100101;
    localparam logic [5:0] FUNC_XOR   = 6'b100110;
    localparam logic [5:0] FUNC_NOR   = 6'b100111;
    localparam logic [5:0] FUNC_SLT   = 6'b101010;
    localparam logic [5:0] FUNC_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10
    } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide with HI/LO (option: EX_MULDIV_FAST_MUL_EN)
module muldiv_unit
    import ex_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_step,
    input  logic               i_start_mul,
    input  logic               i_start_div,
    input  logic               i_signed,
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    input  logic               i_wr_hi,
    input  logic               i_wr_lo,
    output logic               o_busy,
    output logic [NB_DATA-1:0] o_hi,
    output logic [NB_DATA-1:0] o_lo
);
    localparam int NB_CNT = $clog2(NB_DATA);
    localparam logic [NB_CNT-1:0] LAST = NB_CNT'(NB_DATA - 1);

    md_state_e state_q, state_d;
    logic [NB_CNT-1:0] cnt_q, cnt_d;
    logic [2*NB_DATA-1:0] acc_q, acc_d;
    logic [NB_DATA-1:0] op_q, op_d, hi_q, hi_d, lo_q, lo_d;
    logic neg_q, neg_d, sa_q, sa_d, dz_q, dz_d;

    logic [NB_DATA-1:0] mag_a, mag_b;
    logic [2*NB_DATA-1:0] mul_step, mul_prod, div_step;
    logic [NB_DATA:0] div_t;
    logic div_ge, mul_last;

    assign mag_a = (i_signed && i_a[NB_DATA-1]) ? -i_a : i_a;
    assign mag_b = (i_signed && i_b[NB_DATA-1]) ? -i_b : i_b;

`ifdef EX_MULDIV_FAST_MUL_EN
    assign mul_prod = {{NB_DATA{1'b0}}, op_q} * {{NB_DATA{1'b0}}, acc_q[NB_DATA-1:0]};
    assign mul_step = acc_q;
    assign mul_last = 1'b1;
`else
    // acc = {partial sum, remaining multiplier bits}; one shift-add per step
    logic [NB_DATA:0] mul_sum;
    assign mul_sum  = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + (acc_q[0] ? {1'b0, op_q} : '0);
    assign mul_step = {mul_sum, acc_q[NB_DATA-1:1]};
    assign mul_prod = mul_step;
    assign mul_last = (cnt_q == LAST);
`endif

    // acc = {partial remainder, dividend bits becoming quotient bits}
    assign div_t    = {acc_q[2*NB_DATA-1:NB_DATA], acc_q[NB_DATA-1]};
    assign div_ge   = (div_t >= {1'b0, op_q});
    assign div_step = {div_ge ? (div_t[NB_DATA-1:0] - op_q) : div_t[NB_DATA-1:0],
                       acc_q[NB_DATA-2:0], div_ge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        op_d    = op_q;
        neg_d   = neg_q;
        sa_d    = sa_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MD_MUL: begin
                acc_d = mul_step;
                cnt_d = cnt_q + NB_CNT'(1);
                if (mul_last) begin
                    state_d      = MD_IDLE;
                    {hi_d, lo_d} = neg_q ? -mul_prod : mul_prod;
                end
            end
            MD_DIV: begin
                acc_d = div_step;
                cnt_d = cnt_q + NB_CNT'(1);
                if (cnt_q == LAST) begin
                    state_d = MD_IDLE;
                    lo_d    = dz_q ? '1 : (neg_q ? -div_step[NB_DATA-1:0] : div_step[NB_DATA-1:0]);
                    hi_d    = sa_q ? -div_step[2*NB_DATA-1:NB_DATA] : div_step[2*NB_DATA-1:NB_DATA];
                end
            end
            default: begin
                if (i_start_mul || i_start_div) begin
                    state_d = i_start_div ? MD_DIV : MD_MUL;
                    cnt_d   = '0;
                    acc_d   = {{NB_DATA{1'b0}}, i_start_div ? mag_a : mag_b};
                    op_d    = i_start_div ? mag_b : mag_a;
                    neg_d   = i_signed && (i_a[NB_DATA-1] ^ i_b[NB_DATA-1]);
                    sa_d    = i_signed && i_a[NB_DATA-1];
                    dz_d    = (i_b == '0);
                end
                if (i_wr_hi) hi_d = i_a;
                if (i_wr_lo) lo_d = i_a;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (i_step) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            sa_q    <= sa_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign o_busy = (state_q != MD_IDLE);
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule

// File: rtl/ex_muldiv_stage.sv
// rtl/ex_muldiv_stage.sv - MIPS execute stage: forwarding, ALU, mul/div, EX/MEM register (option: EX_MULDIV_FAST_MUL_EN)
module ex_muldiv_stage
    import ex_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_OP   = 6
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_step,
    input  logic [NB_REG-1:0]  i_rt,
    input  logic [NB_REG-1:0]  i_rd,
    input  logic [NB_DATA-1:0] i_reg_DA,
    input  logic [NB_DATA-1:0] i_reg_DB,
    input  logic [NB_DATA-1:0] i_immediate,
    input  logic [NB_OP-1:0]   i_opcode,
    input  logic [NB_OP-1:0]   i_func,
    input  logic [4:0]         i_shamt,
    input  logic               i_regDst,
    input  logic               i_mem2reg,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic               i_immediate_flag,
    input  logic [1:0]         i_aluOP,
    input  logic [1:0]         i_fw_a,
    input  logic [1:0]         i_fw_b,
    input  logic [NB_DATA-1:0] i_output_MEMWB,
    input  logic [NB_DATA-1:0] i_output_EXMEM,
    output logic               o_stall,
    output logic               o_mem2reg,
    output logic               o_memWrite,
    output logic               o_regWrite,
    output logic [NB_REG-1:0]  o_write_reg,
    output logic [NB_DATA-1:0] o_data4Mem,
    output logic [NB_DATA-1:0] o_result
);
    logic [NB_DATA-1:0] op_a, op_b_fw, op_b, alu_res, hi, lo;
    logic is_link, is_rtype, is_mul, is_div, is_md, md_busy;
    logic mem2reg_q, mem2reg_d, memwrite_q, memwrite_d, regwrite_q, regwrite_d;
    logic [NB_REG-1:0] write_reg_q, write_reg_d;
    logic [NB_DATA-1:0] data4mem_q, data4mem_d, result_q, result_d;

    function automatic logic [NB_DATA-1:0] fw_mux(input logic [1:0] sel,
                                                  input logic [NB_DATA-1:0] rf,
                                                  input logic [NB_DATA-1:0] memwb,
                                                  input logic [NB_DATA-1:0] exmem);
        case (sel)
            FW_REG:   return rf;
            FW_ZERO:  return '0;
            FW_MEMWB: return memwb;
            default:  return exmem;
        endcase
    endfunction

    // link instructions carry their return address in the register operands
    assign is_rtype = (i_aluOP == ALUOP_R_TYPE);
    assign is_link  = (i_opcode == OP_JAL) || (is_rtype && i_func == FUNC_JALR);
    assign op_a     = is_link ? i_reg_DA : fw_mux(i_fw_a, i_reg_DA, i_output_MEMWB, i_output_EXMEM);
    assign op_b_fw  = is_link ? i_reg_DB : fw_mux(i_fw_b, i_reg_DB, i_output_MEMWB, i_output_EXMEM);
    assign op_b     = i_immediate_flag ? i_immediate : op_b_fw;

    assign is_mul  = is_rtype && (i_func == FUNC_MULT || i_func == FUNC_MULTU);
    assign is_div  = is_rtype && (i_func == FUNC_DIV  || i_func == FUNC_DIVU);
    assign is_md   = is_mul || is_div || (is_rtype &&
                     (i_func == FUNC_MFHI || i_func == FUNC_MTHI || i_func == FUNC_MFLO || i_func == FUNC_MTLO));
    assign o_stall = md_busy && is_md;

    muldiv_unit #(.NB_DATA(NB_DATA)) u_muldiv (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_step      (i_step),
        .i_start_mul (is_mul),
        .i_start_div (is_div),
        .i_signed    (~i_func[0]),
        .i_a         (op_a),
        .i_b         (op_b),
        .i_wr_hi     (is_rtype && i_func == FUNC_MTHI),
        .i_wr_lo     (is_rtype && i_func == FUNC_MTLO),
        .o_busy      (md_busy),
        .o_hi        (hi),
        .o_lo        (lo)
    );

    always_comb begin
        alu_res = '0;
        case (i_aluOP)
            ALUOP_LOAD_STORE: alu_res = op_a + op_b;
            ALUOP_BRANCH:     alu_res = '0;
            ALUOP_R_TYPE: begin
                case (i_func)
                    FUNC_ADD, FUNC_ADDU: alu_res = op_a + op_b;
                    FUNC_SUB, FUNC_SUBU: alu_res = op_a - op_b;
                    FUNC_AND:  alu_res = op_a & op_b;
                    FUNC_OR:   alu_res = op_a | op_b;
                    FUNC_XOR:  alu_res = op_a ^ op_b;
                    FUNC_NOR:  alu_res = ~(op_a | op_b);
                    FUNC_SLT:  alu_res = {{(NB_DATA-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                    FUNC_SLTU: alu_res = {{(NB_DATA-1){1'b0}}, op_a < op_b};
                    FUNC_SLL:  alu_res = op_b << i_shamt;
                    FUNC_SRL:  alu_res = op_b >> i_shamt;
                    FUNC_SRA:  alu_res = NB_DATA'($signed(op_b) >>> i_shamt);
                    FUNC_JALR: alu_res = op_a;
                    FUNC_MFHI: alu_res = hi;
                    FUNC_MFLO: alu_res = lo;
                    default:   alu_res = '0;
                endcase
            end
            default: begin
                case (i_opcode)
                    OP_ADDI, OP_ADDIU: alu_res = op_a + op_b;
                    OP_SLTI:  alu_res = {{(NB_DATA-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                    OP_SLTIU: alu_res = {{(NB_DATA-1){1'b0}}, op_a < op_b};
                    OP_ANDI:  alu_res = op_a & op_b;
                    OP_ORI:   alu_res = op_a | op_b;
                    OP_XORI:  alu_res = op_a ^ op_b;
                    OP_LUI:   alu_res = op_b << 16;
                    default:  alu_res = '0;
                endcase
            end
        endcase
    end

    // a stalled HI/LO consumer leaves a bubble behind while the unit keeps iterating
    always_comb begin
        mem2reg_d   = 1'b0;
        memwrite_d  = 1'b0;
        regwrite_d  = 1'b0;
        write_reg_d = '0;
        data4mem_d  = '0;
        result_d    = '0;
        if (!o_stall) begin
            mem2reg_d   = i_mem2reg;
            memwrite_d  = i_memWrite;
            regwrite_d  = i_regWrite && !is_mul && !is_div;
            write_reg_d = i_regDst ? i_rd : i_rt;
            data4mem_d  = op_b_fw;
            result_d    = alu_res;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            mem2reg_q   <= 1'b0;
            memwrite_q  <= 1'b0;
            regwrite_q  <= 1'b0;
            write_reg_q <= '0;
            data4mem_q  <= '0;
            result_q    <= '0;
        end else if (i_step) begin
            mem2reg_q   <= mem2reg_d;
            memwrite_q  <= memwrite_d;
            regwrite_q  <= regwrite_d;
            write_reg_q <= write_reg_d;
            data4mem_q  <= data4mem_d;
            result_q    <= result_d;
        end
    end

    assign o_mem2reg   = mem2reg_q;
    assign o_memWrite  = memwrite_q;
    assign o_regWrite  = regwrite_q;
    assign o_write_reg = write_reg_q;
    assign o_data4Mem  = data4mem_q;
    assign o_result    = result_q;

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// tb/tb_ex_muldiv_stage.sv - scoreboard bench for ex_muldiv_stage (honours EX_MULDIV_FAST_MUL_EN)
module tb_ex_muldiv_stage;
`ifdef EX_MULDIV_FAST_MUL_EN
    localparam int MUL_LEN = 1;
`else
    localparam int MUL_LEN = 32;
`endif
    localparam int DIV_LEN = 32;
    localparam logic [1:0] LS = 2'b00, BR = 2'b01, RT = 2'b10, IT = 2'b11;
    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;
    localparam logic [5:0] F_ADD = 6'h20, F_JALR = 6'h09;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic i_reset, i_step;
    logic [4:0] i_rt, i_rd, i_shamt;
    logic [31:0] i_reg_DA, i_reg_DB, i_immediate, i_output_MEMWB, i_output_EXMEM;
    logic [5:0] i_opcode, i_func;
    logic i_regDst, i_mem2reg, i_memWrite, i_regWrite, i_immediate_flag;
    logic [1:0] i_aluOP, i_fw_a, i_fw_b;
    logic o_stall, o_mem2reg, o_memWrite, o_regWrite;
    logic [4:0] o_write_reg;
    logic [31:0] o_data4Mem, o_result;

    ex_muldiv_stage dut (
        .clk(clk), .i_reset(i_reset), .i_step(i_step), .i_rt(i_rt), .i_rd(i_rd),
        .i_reg_DA(i_reg_DA), .i_reg_DB(i_reg_DB), .i_immediate(i_immediate),
        .i_opcode(i_opcode), .i_func(i_func), .i_shamt(i_shamt), .i_regDst(i_regDst),
        .i_mem2reg(i_mem2reg), .i_memWrite(i_memWrite), .i_regWrite(i_regWrite),
        .i_immediate_flag(i_immediate_flag), .i_aluOP(i_aluOP), .i_fw_a(i_fw_a), .i_fw_b(i_fw_b),
        .i_output_MEMWB(i_output_MEMWB), .i_output_EXMEM(i_output_EXMEM), .o_stall(o_stall),
        .o_mem2reg(o_mem2reg), .o_memWrite(o_memWrite), .o_regWrite(o_regWrite),
        .o_write_reg(o_write_reg), .o_data4Mem(o_data4Mem), .o_result(o_result)
    );

    typedef struct packed {
        logic rw, mw, m2r;
        logic [4:0] wr;
        logic [31:0] d4m, res;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e, last_e;
    int total = 0, bad = 0;
    logic act = 1'b0, seen = 1'b0, last_stall;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int busy_left = 0;
    logic [5:0] rfn [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h09, 6'h10, 6'h12};
    logic [5:0] ifn [8]  = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f};
    logic [5:0] mfn [8]  = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic logic [31:0] fwv(input logic [1:0] s, input logic [31:0] r);
        case (s)
            2'b00:   return r;
            2'b01:   return 32'd0;
            2'b10:   return i_output_MEMWB;
            default: return i_output_EXMEM;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b);
        if (i_aluOP == LS) return a + b;
        if (i_aluOP == BR) return 32'd0;
        if (i_aluOP == RT) begin
            case (i_func)
                6'h20, 6'h21: return a + b;
                6'h22, 6'h23: return a - b;
                6'h24: return a & b;
                6'h25: return a | b;
                6'h26: return a ^ b;
                6'h27: return ~(a | b);
                6'h2a: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h2b: return (a < b) ? 32'd1 : 32'd0;
                6'h00: return b << i_shamt;
                6'h02: return b >> i_shamt;
                6'h03: return 32'($signed(b) >>> i_shamt);
                6'h09: return a;
                6'h10: return m_hi;
                6'h12: return m_lo;
                default: return 32'd0;
            endcase
        end
        case (i_opcode)
            6'h08, 6'h09: return a + b;
            6'h0a: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h0b: return (a < b) ? 32'd1 : 32'd0;
            6'h0c: return a & b;
            6'h0d: return a | b;
            6'h0e: return a ^ b;
            6'h0f: return {b[15:0], 16'h0000};
            default: return 32'd0;
        endcase
    endfunction

    task automatic setop(input logic [1:0] aop, input logic [5:0] opc, input logic [5:0] fn,
                         input logic [31:0] da, input logic [31:0] db);
        i_reset = 1'b1; i_step = 1'b1;
        i_aluOP = aop; i_opcode = opc; i_func = fn; i_reg_DA = da; i_reg_DB = db;
        i_fw_a = 2'b00; i_fw_b = 2'b00; i_immediate_flag = 1'b0; i_immediate = $urandom;
        i_shamt = 5'($urandom); i_rt = 5'($urandom); i_rd = 5'($urandom);
        i_regDst = 1'b1; i_regWrite = 1'b1; i_mem2reg = 1'b0; i_memWrite = 1'b0;
        i_output_MEMWB = $urandom; i_output_EXMEM = $urandom;
    endtask

    // evaluate the model for the inputs now applied, then let one clock edge pass
    task automatic tick();
        logic [31:0] a, bf, b;
        logic link, rt, mul, div, md, sgn, stall_exp;
        longint sa, sb, q, r;
        logic [63:0] p;
        exp_t e;
        #1;
        rt   = (i_aluOP == RT);
        link = (i_opcode == 6'b000011) || (rt && i_func == F_JALR);
        a    = link ? i_reg_DA : fwv(i_fw_a, i_reg_DA);
        bf   = link ? i_reg_DB : fwv(i_fw_b, i_reg_DB);
        b    = i_immediate_flag ? i_immediate : bf;
        mul  = rt && (i_func == F_MULT || i_func == F_MULTU);
        div  = rt && (i_func == F_DIV || i_func == F_DIVU);
        md   = mul || div || (rt && i_func inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO});
        sgn  = ~i_func[0];
        stall_exp = (busy_left > 0) && md;
        last_stall = o_stall;
        chk("stall", {63'd0, o_stall}, {63'd0, stall_exp});
        if (!i_reset) begin
            exp_q.push_back('0);
            m_hi = '0; m_lo = '0; busy_left = 0;
        end else if (i_step) begin
            e = '0;
            if (!stall_exp) begin
                e.rw = i_regWrite && !mul && !div; e.mw = i_memWrite; e.m2r = i_mem2reg;
                e.wr = i_regDst ? i_rd : i_rt; e.d4m = bf; e.res = ref_alu(a, b);
            end
            exp_q.push_back(e);
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
            end else if (mul) begin
                if (sgn) begin sa = $signed(a); sb = $signed(b); p = 64'(sa * sb); end
                else p = {32'd0, a} * {32'd0, b};
                p_hi = p[63:32]; p_lo = p[31:0]; busy_left = MUL_LEN;
            end else if (div) begin
                if (b == 0) begin p_lo = '1; p_hi = a; end
                else if (sgn) begin
                    sa = $signed(a); sb = $signed(b); q = sa / sb; r = sa % sb;
                    p_lo = q[31:0]; p_hi = r[31:0];
                end else begin p_lo = a / b; p_hi = a % b; end
                busy_left = DIV_LEN;
            end else if (rt && i_func == F_MTHI) m_hi = a;
            else if (rt && i_func == F_MTLO) m_lo = a;
        end
        @(negedge clk);
    endtask

    // count stalled step cycles while a HI/LO consumer waits, then let it retire
    task automatic wait_consumer(input logic [5:0] fn, input int freeze_at, input int want, input string name);
        int cnt = 0;
        for (int i = 0; i < 200; i++) begin
            setop(RT, 6'd0, fn, $urandom, $urandom);
            i_step = (i >= freeze_at && i < freeze_at + 10) ? 1'b0 : 1'b1;
            tick();
            if (i_step && last_stall) cnt++;
            if (i_step && !last_stall) break;
        end
        chk(name, 64'(cnt), 64'(want));
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 3))
            0:       return 32'(int'($urandom_range(0, 16)) - 8);
            1:       return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    always @(posedge clk) act <= i_step || !i_reset;

    always @(negedge clk) begin
        if (act) begin
            if (exp_q.size() == 0) chk("queue_underflow", 64'd1, 64'd0);
            else begin
                mon_e = exp_q.pop_front();
                chk("regWrite", {63'd0, o_regWrite}, {63'd0, mon_e.rw});
                chk("memWrite", {63'd0, o_memWrite}, {63'd0, mon_e.mw});
                chk("mem2reg", {63'd0, o_mem2reg}, {63'd0, mon_e.m2r});
                chk("write_reg", {59'd0, o_write_reg}, {59'd0, mon_e.wr});
                chk("data4Mem", {32'd0, o_data4Mem}, {32'd0, mon_e.d4m});
                chk("result", {32'd0, o_result}, {32'd0, mon_e.res});
                last_e = mon_e; seen = 1'b1;
            end
        end else if (seen) begin
            chk("hold", {o_regWrite, o_memWrite, o_mem2reg, o_write_reg, o_data4Mem, o_result},
                        {last_e.rw, last_e.mw, last_e.m2r, last_e.wr, last_e.d4m, last_e.res});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        setop(LS, 6'd0, 6'd0, 32'd0, 32'd0);
        i_reset = 1'b0; i_regWrite = 1'b0;
        tick(); tick();

        setop(RT, 6'd0, F_ADD, 32'd100, 32'd200);
        i_fw_a = 2'b11; i_fw_b = 2'b10; i_output_EXMEM = 32'd5; i_output_MEMWB = 32'd7;
        tick();
        setop(RT, 6'd0, F_JALR, 32'h100, 32'd0);
        i_fw_a = 2'b11; i_output_EXMEM = 32'd5;
        tick();

        setop(RT, 6'd0, F_MULT, 32'd7, 32'hFFFFFFFD); tick();
        wait_consumer(F_MFLO, 1000, MUL_LEN, "mult_stall_len");
        setop(RT, 6'd0, F_MFHI, 32'd0, 32'd0); tick();

        setop(RT, 6'd0, F_DIV, 32'hFFFFFFF9, 32'd2); tick();
        wait_consumer(F_MFLO, 1000, DIV_LEN, "div_stall_len");
        setop(RT, 6'd0, F_MFHI, 32'd0, 32'd0); tick();
        setop(RT, 6'd0, F_DIVU, 32'd7, 32'd0); tick();
        wait_consumer(F_MFHI, 1000, DIV_LEN, "divu0_stall_len");
        setop(RT, 6'd0, F_MFLO, 32'd0, 32'd0); tick();

        setop(RT, 6'd0, F_DIV, 32'd1000, 32'hFFFFFFF3); tick();
        wait_consumer(F_MFLO, 8, DIV_LEN, "div_frozen_stall_len");

        setop(RT, 6'd0, F_MULTU, 32'hDEADBEEF, 32'h12345); tick();
        for (int i = 0; i < 15; i++) begin setop(RT, 6'd0, F_ADD, rnd(), rnd()); tick(); end
        i_reset = 1'b0; tick();
        setop(RT, 6'd0, F_MFHI, 32'd0, 32'd0); tick();
        setop(RT, 6'd0, F_MFLO, 32'd0, 32'd0); tick();

        setop(RT, 6'd0, F_MULTU, 32'hFFFFFFFF, 32'd2); tick();
        wait_consumer(F_MFHI, 1000, MUL_LEN, "multu_stall_len");

        for (int n = 0; n < 500; n++) begin
            int k;
            k = $urandom_range(0, 19);
            if (k < 6)       setop(RT, 6'd0, rfn[$urandom_range(0, 15)], rnd(), rnd());
            else if (k < 9)  begin setop(IT, ifn[$urandom_range(0, 7)], 6'd0, rnd(), rnd()); i_immediate_flag = 1'b1; i_immediate = rnd(); end
            else if (k < 10) begin setop(LS, 6'd0, 6'd0, rnd(), rnd()); i_immediate_flag = 1'b1; i_mem2reg = 1'($urandom); i_memWrite = 1'($urandom); end
            else if (k < 11) setop(BR, 6'd0, 6'd0, rnd(), rnd());
            else if (k < 12) setop(LS, 6'b000011, 6'd0, rnd(), rnd());
            else             setop(RT, 6'd0, mfn[$urandom_range(0, 7)], rnd(), rnd());
            i_fw_a = 2'($urandom); i_fw_b = 2'($urandom);
            i_regDst = 1'($urandom); i_regWrite = 1'($urandom);
            if ($urandom_range(0, 9) == 0) i_step = 1'b0;
            if ($urandom_range(0, 149) == 0) i_reset = 1'b0;
            tick();
        end

        i_step = 1'b0; i_reset = 1'b1;
        @(negedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
